// File: rtl/arriskv_pkg.sv
// Shared RV32I front-end types: opcode encodings, decoded-entry layout and
// buffer states used by the decode stage.
package arriskv_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        IT_R = 3'd0,
        IT_I = 3'd1,
        IT_S = 3'd2,
        IT_B = 3'd3,
        IT_U = 3'd4,
        IT_J = 3'd5
    } instr_type_t;

    typedef enum logic [3:0] {
        CL_OP     = 4'd0,
        CL_OP_IMM = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_BRANCH = 4'd4,
        CL_JAL    = 4'd5,
        CL_JALR   = 4'd6,
        CL_LUI    = 4'd7,
        CL_AUIPC  = 4'd8,
        CL_SYSTEM = 4'd9
    } op_class_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rdest;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        instr_type_t     instr_type;
        op_class_t       op_class;
        logic [XLEN-1:0] immediate;
        logic [PC_W-1:0] pc;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_we;
        logic            illegal;
    } decoded_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational RV32I decode of one instruction word and its PC into
// a decoded_t entry, including the illegal-instruction check.
module instr_decode_comb
    import arriskv_pkg::*;
#(
    parameter int wd_instr_p = 32,
    parameter int wd_xlen_p  = 32,
    parameter int wd_pc_p    = 32
) (
    input  logic [wd_instr_p-1:0] instr_i,
    input  logic [wd_pc_p-1:0]    pc_i,
    output decoded_t              dec_o
);

    logic [6:0]           opc_s;
    logic [2:0]           f3_s;
    logic [6:0]           f7_s;
    instr_type_t          typ_s;
    op_class_t            cls_s;
    logic                 ill_class_s;
    logic                 ill_s;
    logic                 system_s;
    logic [wd_xlen_p-1:0] imm_s;

    assign opc_s    = instr_i[6:0];
    assign f3_s     = instr_i[14:12];
    assign f7_s     = instr_i[31:25];
    assign system_s = (opc_s == OPC_SYSTEM);
    // Any word whose low two bits are not 11 falls into the default arm as well.
    assign ill_s    = ill_class_s | (instr_i[1:0] != 2'b11);

    // Opcode classification and per-class encoding legality.
    always_comb begin
        typ_s       = IT_R;
        cls_s       = CL_OP;
        ill_class_s = 1'b0;
        case (opc_s)
            OPC_OP: begin
                typ_s       = IT_R;
                cls_s       = CL_OP;
                ill_class_s = !((f7_s == 7'b0000000) || (f7_s == 7'b0100000)) ||
                              ((f7_s == 7'b0100000) && !((f3_s == 3'b000) || (f3_s == 3'b101)));
            end
            OPC_OP_IMM: begin
                typ_s       = IT_I;
                cls_s       = CL_OP_IMM;
                ill_class_s = ((f3_s == 3'b001) && (f7_s != 7'b0000000)) ||
                              ((f3_s == 3'b101) && !((f7_s == 7'b0000000) || (f7_s == 7'b0100000)));
            end
            OPC_LOAD: begin
                typ_s       = IT_I;
                cls_s       = CL_LOAD;
                ill_class_s = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
            end
            OPC_JALR: begin
                typ_s       = IT_I;
                cls_s       = CL_JALR;
                ill_class_s = (f3_s != 3'b000);
            end
            OPC_SYSTEM: begin
                typ_s       = IT_I;
                cls_s       = CL_SYSTEM;
                ill_class_s = (instr_i[31:0] != INSTR_ECALL) && (instr_i[31:0] != INSTR_EBREAK);
            end
            OPC_STORE: begin
                typ_s       = IT_S;
                cls_s       = CL_STORE;
                ill_class_s = (f3_s >= 3'b011);
            end
            OPC_BRANCH: begin
                typ_s       = IT_B;
                cls_s       = CL_BRANCH;
                ill_class_s = (f3_s == 3'b010) || (f3_s == 3'b011);
            end
            OPC_LUI: begin
                typ_s       = IT_U;
                cls_s       = CL_LUI;
                ill_class_s = 1'b0;
            end
            OPC_AUIPC: begin
                typ_s       = IT_U;
                cls_s       = CL_AUIPC;
                ill_class_s = 1'b0;
            end
            OPC_JAL: begin
                typ_s       = IT_J;
                cls_s       = CL_JAL;
                ill_class_s = 1'b0;
            end
            default: begin
                typ_s       = IT_R;
                cls_s       = CL_OP;
                ill_class_s = 1'b1;
            end
        endcase
    end

    // Immediate assembly per instruction format.
    always_comb begin
        imm_s = '0;
        case (typ_s)
            IT_I: imm_s = sext32({{20{instr_i[31]}}, instr_i[31:20]});
            IT_S: imm_s = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
            IT_B: imm_s = sext32({{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                  instr_i[30:25], instr_i[11:8], 1'b0});
            IT_U: imm_s = sext32({instr_i[31:12], 12'b0});
            IT_J: imm_s = sext32({{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                  instr_i[20], instr_i[30:21], 1'b0});
            default: imm_s = '0;
        endcase
    end

    // Field extraction and register-usage flags.
    always_comb begin
        dec_o            = '0;
        dec_o.rs1        = instr_i[19:15];
        dec_o.rs2        = instr_i[24:20];
        dec_o.rdest      = instr_i[11:7];
        dec_o.funct3     = f3_s;
        dec_o.funct7     = f7_s;
        dec_o.instr_type = typ_s;
        dec_o.op_class   = cls_s;
        dec_o.immediate  = imm_s;
        dec_o.pc         = pc_i;
        dec_o.rs1_used   = !((typ_s == IT_U) || (typ_s == IT_J) || system_s);
        dec_o.rs2_used   = (typ_s == IT_R) || (typ_s == IT_S) || (typ_s == IT_B);
        dec_o.rd_we      = !((typ_s == IT_S) || (typ_s == IT_B) || system_s || ill_s) &&
                           (instr_i[11:7] != 5'd0);
        dec_o.illegal    = ill_s;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: valid/ready handshake, OUT + SKID two-entry
// buffer and synchronous flush, around the combinational decoder.
module decode_stage
    import arriskv_pkg::*;
#(
    parameter int wd_instr_p = 32,
    parameter int wd_xlen_p  = 32,
    parameter int wd_pc_p    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready_up,
    input  logic [wd_instr_p-1:0] i_instr,
    input  logic [wd_pc_p-1:0]    i_pc,
    output logic                  o_valid,
    input  logic                  i_ready_dn,
    output decoded_t              o_dec
);

    decoded_t   dec_s;
    decoded_t   out_q;
    decoded_t   skid_q;
    buf_state_t state_q;
    logic       valid_q;
    logic       ready_q;
    logic       accept_s;
    logic       drain_s;

    instr_decode_comb #(
        .wd_instr_p (wd_instr_p),
        .wd_xlen_p  (wd_xlen_p),
        .wd_pc_p    (wd_pc_p)
    ) u_decode (
        .instr_i (i_instr),
        .pc_i    (i_pc),
        .dec_o   (dec_s)
    );

    assign accept_s   = i_valid && ready_q;
    assign drain_s    = valid_q && i_ready_dn;
    assign o_valid    = valid_q;
    assign o_ready_up = ready_q;
    assign o_dec      = out_q;

    // Buffer FSM; ready drops only in TWO, so accept and drain never coincide there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (i_flush) begin
            state_q <= BUF_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        out_q   <= dec_s;
                        valid_q <= 1'b1;
                        state_q <= BUF_ONE;
                    end else begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_ONE: begin
                    if (accept_s && drain_s) begin
                        out_q <= dec_s;
                    end else if (accept_s) begin
                        skid_q  <= dec_s;
                        ready_q <= 1'b0;
                        state_q <= BUF_TWO;
                    end else if (drain_s) begin
                        valid_q <= 1'b0;
                        state_q <= BUF_EMPTY;
                    end else begin
                        state_q <= BUF_ONE;
                    end
                end
                BUF_TWO: begin
                    if (drain_s) begin
                        out_q   <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= BUF_ONE;
                    end else begin
                        state_q <= BUF_TWO;
                    end
                end
                default: begin
                    state_q <= BUF_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-written expected decodes are queued
// on accept and compared against o_dec while the entry is presented.
module tb_decode_stage;
    import arriskv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready_up;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        o_valid;
    logic        i_ready_dn;
    decoded_t    o_dec;

    typedef struct {
        logic [31:0] instr;
        instr_type_t t;
        op_class_t   c;
        logic [31:0] imm;
        logic [3:0]  fl;    // {rs1_used, rs2_used, rd_we, illegal}
        bit          full;  // compare whole entry, else only illegal/rd_we
    } vec_t;

    typedef struct {
        decoded_t d;
        bit       full;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_idx  = 0;
    logic [31:0] pc_ctr   = 32'h0000_1000;
    bit          bp_en    = 1'b0;

    decode_stage #(
        .wd_instr_p (32),
        .wd_xlen_p  (32),
        .wd_pc_p    (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .o_ready_up (o_ready_up),
        .i_instr    (i_instr),
        .i_pc       (i_pc),
        .o_valid    (o_valid),
        .i_ready_dn (i_ready_dn),
        .o_dec      (o_dec)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] instr, input instr_type_t t, input op_class_t c,
                                 input logic [31:0] imm, input logic [3:0] fl, input bit full);
        vec_t v;
        v.instr = instr; v.t = t; v.c = c; v.imm = imm; v.fl = fl; v.full = full;
        return v;
    endfunction

    function automatic exp_t mk_exp(input vec_t v, input logic [31:0] pc);
        exp_t e;
        e.d            = '0;
        e.d.rs1        = v.instr[19:15];
        e.d.rs2        = v.instr[24:20];
        e.d.rdest      = v.instr[11:7];
        e.d.funct3     = v.instr[14:12];
        e.d.funct7     = v.instr[31:25];
        e.d.instr_type = v.t;
        e.d.op_class   = v.c;
        e.d.immediate  = v.imm;
        e.d.pc         = pc;
        {e.d.rs1_used, e.d.rs2_used, e.d.rd_we, e.d.illegal} = v.fl;
        e.full         = v.full;
        return e;
    endfunction

    // Scoreboard: compare the head while valid, pop on drain, push on accept.
    always @(negedge clk) begin
        if (!rst_n || i_flush) begin
            sb.delete();
        end else begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 128'(o_valid), 128'(1'b0));
                end else begin
                    if (sb[0].full) begin
                        check_eq("dec", 128'(o_dec), 128'(sb[0].d));
                    end else begin
                        check_eq("illegal", 128'(o_dec.illegal), 128'(sb[0].d.illegal));
                        check_eq("rd_we", 128'(o_dec.rd_we), 128'(sb[0].d.rd_we));
                    end
                    if (i_ready_dn) void'(sb.pop_front());
                end
            end
            if (i_valid && o_ready_up) sb.push_back(mk_exp(vecs[cur_idx], i_pc));
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en) i_ready_dn = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic present(input int idx);
        cur_idx = idx;
        i_instr = vecs[idx].instr;
        i_pc    = pc_ctr;
        pc_ctr  = pc_ctr + 32'd4;
        i_valid = 1'b1;
    endtask

    task automatic send(input int idx);
        bit acc;
        present(idx);
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = o_ready_up;
            @(posedge clk); #1;
        end
        check_eq("send_accepted", 128'(acc), 128'(1'b1));
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready_dn = 1'b1;
        i_instr = 32'd0; i_pc = 32'd0;

        vecs.push_back(mkv(32'hFFF10093, IT_I, CL_OP_IMM, 32'hFFFFFFFF, 4'b1010, 1'b1)); // 0 addi x1,x2,-1
        vecs.push_back(mkv(32'h123452B7, IT_U, CL_LUI,    32'h12345000, 4'b0010, 1'b1)); // 1 lui
        vecs.push_back(mkv(32'hFE208EE3, IT_B, CL_BRANCH, 32'hFFFFFFFC, 4'b1100, 1'b1)); // 2 beq -4
        vecs.push_back(mkv(32'h00000000, IT_R, CL_OP,     32'h00000000, 4'b0001, 1'b0)); // 3 zero word
        vecs.push_back(mkv(32'h40001033, IT_R, CL_OP,     32'h00000000, 4'b1101, 1'b1)); // 4 bad funct7/funct3
        vecs.push_back(mkv(32'h00100073, IT_I, CL_SYSTEM, 32'h00000001, 4'b0000, 1'b1)); // 5 ebreak
        vecs.push_back(mkv(32'h00000073, IT_I, CL_SYSTEM, 32'h00000000, 4'b0000, 1'b1)); // 6 ecall
        vecs.push_back(mkv(32'h00112223, IT_S, CL_STORE,  32'h00000004, 4'b1100, 1'b1)); // 7 sw x1,4(x2)
        vecs.push_back(mkv(32'h008000EF, IT_J, CL_JAL,    32'h00000008, 4'b0010, 1'b1)); // 8 jal x1,8
        vecs.push_back(mkv(32'h002081B3, IT_R, CL_OP,     32'h00000000, 4'b1110, 1'b1)); // 9 add
        vecs.push_back(mkv(32'h402081B3, IT_R, CL_OP,     32'h00000000, 4'b1110, 1'b1)); // 10 sub
        vecs.push_back(mkv(32'h00412083, IT_I, CL_LOAD,   32'h00000004, 4'b1010, 1'b1)); // 11 lw
        vecs.push_back(mkv(32'h000090E7, IT_I, CL_JALR,   32'h00000000, 4'b1001, 1'b1)); // 12 jalr f3=1
        vecs.push_back(mkv(32'h00100013, IT_I, CL_OP_IMM, 32'h00000001, 4'b1000, 1'b1)); // 13 addi x0
        vecs.push_back(mkv(32'hFFFFF317, IT_U, CL_AUIPC,  32'hFFFFF000, 4'b0010, 1'b1)); // 14 auipc
        vecs.push_back(mkv(32'h02009093, IT_I, CL_OP_IMM, 32'h00000020, 4'b1001, 1'b1)); // 15 slli bad f7

        // Reset state
        idle(2);
        @(negedge clk);
        check_eq("rst_valid", 128'(o_valid), 128'(1'b0));
        check_eq("rst_ready", 128'(o_ready_up), 128'(1'b1));
        check_eq("rst_dec", 128'(o_dec), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-cycle latency, then a back-to-back stream at full throughput
        send(0);
        @(negedge clk);
        check_eq("latency_valid", 128'(o_valid), 128'(1'b1));
        @(posedge clk); #1;
        for (int i = 1; i < 16; i++) send(i);
        idle(3);
        check_eq("stream_drained", 128'(sb.size()), 128'(0));

        // Backpressure: A in OUT, B in SKID, C held until release
        i_ready_dn = 1'b0;
        send(0);
        send(1);
        present(2);
        @(negedge clk);
        check_eq("bp_ready_low", 128'(o_ready_up), 128'(1'b0));
        check_eq("bp_out_a_imm", 128'(o_dec.immediate), 128'(32'hFFFFFFFF));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("bp_c_held", 128'(o_ready_up), 128'(1'b0));
        @(posedge clk); #1;
        i_ready_dn = 1'b1;
        @(negedge clk);
        check_eq("bp_a_out", 128'(o_valid), 128'(1'b1));
        @(negedge clk);
        check_eq("bp_b_out", 128'(o_valid), 128'(1'b1));
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_c_out", 128'(o_valid), 128'(1'b1));
        @(negedge clk);
        check_eq("bp_done_valid", 128'(o_valid), 128'(1'b0));
        check_eq("bp_sb_empty", 128'(sb.size()), 128'(0));
        @(posedge clk); #1;

        // Flush with two entries held and an input presented
        i_ready_dn = 1'b0;
        send(3);
        send(4);
        present(5);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        check_eq("flush2_valid", 128'(o_valid), 128'(1'b0));
        check_eq("flush2_ready", 128'(o_ready_up), 128'(1'b1));
        @(posedge clk); #1;
        i_ready_dn = 1'b1;
        idle(4);

        // Flush in ONE while an acceptable input is presented
        i_ready_dn = 1'b0;
        send(6);
        present(7);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        check_eq("flush1_valid", 128'(o_valid), 128'(1'b0));
        check_eq("flush1_ready", 128'(o_ready_up), 128'(1'b1));
        @(posedge clk); #1;
        i_ready_dn = 1'b1;
        idle(4);

        // Reset mid-operation clears the entry as well
        i_ready_dn = 1'b0;
        send(8);
        send(9);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mrst_valid", 128'(o_valid), 128'(1'b0));
        check_eq("mrst_ready", 128'(o_ready_up), 128'(1'b1));
        check_eq("mrst_dec", 128'(o_dec), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_ready_dn = 1'b1;
        idle(2);

        // Random backpressure pass over the whole table
        bp_en = 1'b1;
        for (int i = 0; i < 16; i++) send(i);
        bp_en = 1'b0;
        @(posedge clk); #1;
        i_ready_dn = 1'b1;
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
        check_eq("rand_sb_empty", 128'(sb.size()), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rand_final_valid", 128'(o_valid), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I instruction decode stage with a valid/ready handshake and a 2-entry skid buffer. Decodes all RV32I base opcodes, produces sign-extended immediates, register-usage flags and an illegal-instruction flag. Sits between fetch and execute, and carries the PC alongside the instruction. Supports backpressure and a synchronous pipeline flush.

## Interface
- `wd_instr_p`, 32: instruction width; only 32 is supported.
- `wd_xlen_p`, 32: immediate/datapath width; must be ≥ 32.
- `wd_pc_p`, 32: PC width, passed through unchanged.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_flush` in 1: drops all held entries and any input presented this cycle.
- `i_valid` in 1: fetch has an instruction.
- `o_ready_up` out 1: stage can accept.
- `i_instr` in `wd_instr_p`: instruction word.
- `i_pc` in `wd_pc_p`: PC of `i_instr`.
- `o_valid` out 1: decoded entry available.
- `i_ready_dn` in 1: execute accepts.
- `o_dec` out `decoded_t`: decoded entry.

## Operation
- **Decoded fields.** `decoded_t` holds: rs1, rs2, rdest, funct3, funct7, `instr_type` (R/I/S/B/U/J), `op_class`, `immediate[wd_xlen_p]`, `pc`, `rs1_used`, `rs2_used`, `rd_we` and `illegal`.
- **Opcode classes.**
  - 0110011 OP → R.
  - 0010011 OP_IMM, 0000011 LOAD, 1100111 JALR and 1110011 SYSTEM → I.
  - 0100011 STORE → S.
  - 1100011 BRANCH → B.
  - 0110111 LUI and 0010111 AUIPC → U.
  - 1101111 JAL → J.
- **Immediates.**
  - I, S, B and J immediates are sign-extended from instr[31].
  - B and J immediates have bit 0 = 0.
  - U immediate = {instr[31:12], 12'b0}, sign-extended.
  - R immediate = 0.
- **Usage flags.**
  - `rs1_used` = 0 for U, J and SYSTEM.
  - `rs2_used` = 1 only for R, S and B.
  - `rd_we` = 0 for S, B, SYSTEM, illegal, and any rdest = 0.
- **Illegal conditions.**
  - instr[1:0] ≠ 11, or an unknown opcode.
  - OP with funct7 ∉ {0000000, 0100000}, or with 0100000 and funct3 ∉ {000, 101}.
  - OP_IMM funct3 001 with funct7 ≠ 0.
  - OP_IMM funct3 101 with funct7 ∉ {0000000, 0100000}.
  - JALR with funct3 ≠ 000.
  - BRANCH with funct3 ∈ {010, 011}.
  - LOAD with funct3 ∈ {011, 110, 111}.
  - STORE with funct3 ≥ 011.
  - SYSTEM other than ECALL (0x00000073) or EBREAK (0x00100073).
- **Illegal handling.** An illegal entry still propagates with `illegal` = 1, `rd_we` = 0 and its fields as extracted.
- **Buffering.** There are two entries: the output register (OUT) and a skid register (SKID).
  - Accept when `i_valid` && `o_ready_up`.
  - Accepted data goes to OUT if OUT is empty or is draining this cycle and SKID is empty; otherwise it goes to SKID.
  - When OUT drains and SKID is full, SKID moves to OUT.
- **Buffer states.** EMPTY, ONE (OUT full) and TWO (OUT and SKID full).
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without drain.
  - ONE → EMPTY on drain without accept.
  - TWO → ONE on drain.
- **Flush.** `i_flush` takes priority over all other events: next state EMPTY, and any input that cycle is discarded.

## Timing
- **Reset.** `o_valid` = 0, `o_ready_up` = 1, `o_dec` = 0, state EMPTY.
- **Latency.** An instruction accepted in cycle N appears at `o_valid`/`o_dec` in cycle N+1, when the buffer is not backpressured.
- **Ready.** `o_ready_up` is registered and equals (state ≠ TWO).
- **Throughput.** One instruction per cycle while `i_ready_dn` = 1.
- **Output stability.** `o_dec` is stable while `o_valid` && !`i_ready_dn`.
- **Simultaneous events.**
  - Accept and drain in ONE: the state stays ONE and OUT takes the new entry.
  - Drain in TWO with accept is impossible, because `o_ready_up` = 0 in TWO.
- **Flush timing.** The cycle after a flush has `o_valid` = 0 and `o_ready_up` = 1.
- **Mid-operation reset.** Reset asserted mid-operation behaves identically to a flush and also clears `o_dec`.

## Structure
- **Shared package** `arriskv_pkg`, which holds:
  - `instr_type_t`;
  - `op_class_t` (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - `decoded_t`;
  - opcode localparams;
  - ECALL/EBREAK constants.
- **Sub-module** `instr_decode_comb`: the purely combinational decode of `i_instr` and `i_pc` into `decoded_t`. `decode_stage` owns the buffering and FSM.

## Test plan
- **I-type decode.** 0xFFF10093 (addi x1,x2,-1) → type I, rs1 = 2, rdest = 1, imm 0xFFFFFFFF, `rd_we` = 1, `illegal` = 0, `o_valid` one cycle later.
- **U-type decode.** 0x123452B7 (lui x5,0x12345) → type U, imm 0x12345000, `rs1_used` = 0, `rd_we` = 1.
- **B-type decode.** 0xFE208EE3 (beq x1,x2,-4) → type B, imm 0xFFFFFFFC, `rs2_used` = 1, `rd_we` = 0.
- **Illegal words.**
  - 0x00000000 → `illegal` = 1, `rd_we` = 0.
  - 0x40001033 (funct7 0100000, funct3 001) → `illegal` = 1.
  - 0x00100073 (EBREAK) → `illegal` = 0.
- **Backpressure.** Hold `i_ready_dn` = 0 and push A, B, C back-to-back.
  - A is in OUT and B is in SKID.
  - `o_ready_up` drops the cycle after B is accepted, and C is held.
  - Release `i_ready_dn`: A, B and C emerge on consecutive cycles in order.
- **Flush.** With TWO entries held, assert `i_flush` together with `i_valid`.
  - Next cycle: `o_valid` = 0 and `o_ready_up` = 1.
  - The flushed-cycle input never appears.
